// File: rtl/wb_arbiter_pkg.sv
// Shared constants and state encoding for the wishbone round-robin arbiter.
package wb_arbiter_pkg;
  localparam int WB_DATA_BITS = 32;
  localparam int WB_SEL_BITS  = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between N wishbone masters, the arbiter and the shared slave.
interface wb_arbiter_if #(
  parameter int MASTER_NUM    = 4,
  parameter int DEV_ADDR_BITS = 8
);
  import wb_arbiter_pkg::*;
  localparam int AW = DEV_ADDR_BITS - 2;

  logic [MASTER_NUM-1:0]              m_cs_i;
  logic [MASTER_NUM*AW-1:0]           m_addr_i;
  logic [MASTER_NUM*WB_SEL_BITS-1:0]  m_sel_i;
  logic [MASTER_NUM*WB_DATA_BITS-1:0] m_data_i;
  logic [MASTER_NUM-1:0]              m_we_i;
  logic [WB_DATA_BITS-1:0]            m_data_o;
  logic [MASTER_NUM-1:0]              m_ack_o;
  logic                               s_cs_o;
  logic [AW-1:0]                      s_addr_o;
  logic [WB_SEL_BITS-1:0]             s_sel_o;
  logic [WB_DATA_BITS-1:0]            s_data_o;
  logic                               s_we_o;
  logic [WB_DATA_BITS-1:0]            s_data_i;
  logic                               s_ack_i;

  // Arbiter view: serves the masters, drives the shared slave.
  modport slave (
    input  m_cs_i, m_addr_i, m_sel_i, m_data_i, m_we_i, s_data_i, s_ack_i,
    output m_data_o, m_ack_o, s_cs_o, s_addr_o, s_sel_o, s_data_o, s_we_o
  );

  // Environment view: the masters plus the slave device.
  modport master (
    output m_cs_i, m_addr_i, m_sel_i, m_data_i, m_we_i, s_data_i, s_ack_i,
    input  m_data_o, m_ack_o, s_cs_o, s_addr_o, s_sel_o, s_data_o, s_we_o
  );
endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or above the pointer, with wrap.
module wb_rr_pick #(
  parameter int MASTER_NUM = 4,
  parameter int IW         = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] i_req,
  input  logic [IW-1:0]         i_ptr,
  output logic [MASTER_NUM-1:0] o_onehot,
  output logic [IW-1:0]         o_idx,
  output logic                  o_any
);
  int j;

  always_comb begin
    j        = 0;
    o_any    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      j = (int'(i_ptr) + i) % MASTER_NUM;
      if (!o_any && i_req[j]) begin
        o_any = 1'b1;
        o_idx = IW'(j);
      end
    end
    o_onehot[o_idx] = o_any;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one wishbone slave among MASTER_NUM masters.
// Define WB_ARB_TIMEOUT_EN to force-complete cycles after TIMEOUT_CYCLES BUSY cycles.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int MASTER_NUM     = 4,
  parameter int DEV_ADDR_BITS  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_arbiter_if.slave           bus,
  output logic [MASTER_NUM-1:0] grant_o,
  output logic                  busy_o
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);
  localparam int AW = DEV_ADDR_BITS - 2;
  localparam int IW = $clog2(MASTER_NUM);

  arb_state_e            r_state;
  logic [MASTER_NUM-1:0] r_grant;
  logic                  r_busy;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         r_ptr;
  logic [MASTER_NUM-1:0] w_onehot;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_cs_k;
  logic                  w_tmo;

  wb_rr_pick #(.MASTER_NUM(MASTER_NUM), .IW(IW)) u_pick (
    .i_req   (bus.m_cs_i),
    .i_ptr   (r_ptr),
    .o_onehot(w_onehot),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_cs_k  = bus.m_cs_i[r_idx];
  assign grant_o = r_grant;
  assign busy_o  = r_busy;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 256) ? 8 : 16;
  logic [CW-1:0] r_tcnt;

  // Counts BUSY cycles; zero during the first BUSY cycle after a grant.
  always_ff @(posedge clk) begin
    if (rst || r_state == ARB_IDLE) r_tcnt <= '0;
    else                            r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_tmo     = (r_state == ARB_BUSY) && (r_tcnt == CW'(TIMEOUT_CYCLES - 1)) && !bus.s_ack_i;
  assign timeout_o = w_tmo;
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    bus.s_cs_o   = 1'b0;
    bus.s_addr_o = '0;
    bus.s_sel_o  = '0;
    bus.s_data_o = '0;
    bus.s_we_o   = 1'b0;
    bus.m_ack_o  = '0;
    bus.m_data_o = '0;
    if (r_state == ARB_BUSY) begin
      bus.s_cs_o         = w_cs_k;
      bus.s_addr_o       = bus.m_addr_i[int'(r_idx)*AW +: AW];
      bus.s_sel_o        = bus.m_sel_i[int'(r_idx)*WB_SEL_BITS +: WB_SEL_BITS];
      bus.s_data_o       = bus.m_data_i[int'(r_idx)*WB_DATA_BITS +: WB_DATA_BITS];
      bus.s_we_o         = bus.m_we_i[r_idx];
      bus.m_ack_o[r_idx] = bus.s_ack_i | w_tmo;
      bus.m_data_o       = w_tmo ? '0 : bus.s_data_i;
    end
  end

  // Grant is only made from IDLE, so the bus is always released for one cycle after ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: if (w_any) begin
          r_state <= ARB_BUSY;
          r_grant <= w_onehot;
          r_busy  <= 1'b1;
          r_idx   <= w_idx;
          r_ptr   <= (int'(w_idx) == MASTER_NUM - 1) ? '0 : w_idx + 1'b1;
        end
        ARB_BUSY: if (bus.s_ack_i || !w_cs_k || w_tmo) begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + randomized bench for wb_arbiter with a registered slave and a rotation model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int NM  = 4;
  localparam int DAB = 8;
  localparam int AW  = DAB - 2;
  localparam int NW  = 1 << AW;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clk;
  logic          rst;
  logic [NM-1:0] grant_o;
  logic          busy_o;
`ifdef WB_ARB_TIMEOUT_EN
  logic          timeout_o;
`endif
  int checks = 0;
  int errors = 0;

  wb_arbiter_if #(.MASTER_NUM(NM), .DEV_ADDR_BITS(DAB)) bus();

  wb_arbiter #(.MASTER_NUM(NM), .DEV_ADDR_BITS(DAB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .grant_o  (grant_o),
`ifdef WB_ARB_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave device: one-cycle registered ack ----------------
  logic        r_sack;
  logic [31:0] r_sdata;
  logic [31:0] smem [0:NW-1];
  logic        ack_en;
  logic        force_ack;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h000000A5 : (32'hC0DE0000 | 32'(i));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      r_sack  <= 1'b0;
      r_sdata <= '0;
      for (int i = 0; i < NW; i++) smem[i] <= init_word(i);
    end else if (bus.s_cs_o && !bus.s_ack_i) begin
      r_sack  <= ack_en;
      r_sdata <= smem[bus.s_addr_o];
      if (ack_en && bus.s_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.s_sel_o[b]) smem[bus.s_addr_o][b*8 +: 8] <= bus.s_data_o[b*8 +: 8];
    end else begin
      r_sack <= 1'b0;
    end
  end

  assign bus.s_ack_i  = r_sack | force_ack;
  assign bus.s_data_i = r_sdata;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:NW-1];
  int          mptr;

  function automatic int pick(input logic [NM-1:0] p, input int ptr);
    for (int i = 0; i < NM; i++)
      if (p[(ptr + i) % NM]) return (ptr + i) % NM;
    return -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    mptr = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic we, input logic [AW-1:0] a,
                       input logic [3:0] sel, input logic [31:0] d);
    bus.m_we_i[k]           = we;
    bus.m_addr_i[k*AW +: AW] = a;
    bus.m_sel_i[k*4 +: 4]   = sel;
    bus.m_data_i[k*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.m_cs_i = '0;
    bus.m_we_i = '0;
    step();
    step();
    rst = 1'b0;
    ref_reset();
  endtask

  // Single uncontended transfer; rd gets the data seen with the ack.
  task automatic xfer(input int k, input logic we, input logic [AW-1:0] a,
                      input logic [3:0] sel, input logic [31:0] d, output logic [31:0] rd);
    int cyc;
    cyc = 0;
    set_m(k, we, a, sel, d);
    bus.m_cs_i[k] = 1'b1;
    do begin step(); cyc++; end while (bus.m_ack_o == '0 && cyc < 20);
    chk("xfer_ack", 32'(bus.m_ack_o), 32'(1 << k));
    rd = bus.m_data_o;
    if (we) ref_mem[a] = merge(ref_mem[a], sel, d);
    bus.m_cs_i[k] = 1'b0;
    bus.m_we_i[k] = 1'b0;
    mptr = (k + 1) % NM;
    step();
  endtask

  // Random set of simultaneous requests; serve order predicted by the rotation rule.
  task automatic run_batch(input logic [NM-1:0] req);
    logic [NM-1:0] pend;
    logic [AW-1:0] a [NM];
    logic [3:0]    s [NM];
    logic [31:0]   d [NM];
    logic          w [NM];
    int            cyc;
    int            ek;
    pend = req;
    for (int i = 0; i < NM; i++) begin
      a[i] = AW'($urandom);
      s[i] = 4'($urandom_range(1, 15));
      d[i] = $urandom;
      w[i] = 1'($urandom);
      set_m(i, w[i], a[i], s[i], d[i]);
    end
    bus.m_cs_i = req;
    cyc = 0;
    while (pend != '0 && cyc < 60) begin
      step();
      cyc++;
      chk("rnd_ack_in_grant", 32'(bus.m_ack_o & ~grant_o), 32'h0);
      chk("rnd_cs_busy", 32'(bus.s_cs_o & ~busy_o), 32'h0);
      if (bus.m_ack_o != '0) begin
        ek = pick(pend, mptr);
        chk("rnd_order", 32'(bus.m_ack_o), 32'(1 << ek));
        if (!w[ek]) chk("rnd_rdata", bus.m_data_o, ref_mem[a[ek]]);
        else        ref_mem[a[ek]] = merge(ref_mem[a[ek]], s[ek], d[ek]);
        pend[ek]   = 1'b0;
        bus.m_cs_i = bus.m_cs_i & ~bus.m_ack_o;
        bus.m_cs_i[ek] = 1'b0;
        mptr = (ek + 1) % NM;
      end
    end
    chk("rnd_drain", 32'(pend), 32'h0);
    bus.m_cs_i = '0;
    step();
    chk("rnd_idle", 32'(grant_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int          n;
    int          cyc;
    logic        pulse_ok;
    logic        busy_ok;

    rst          = 1'b1;
    ack_en       = 1'b1;
    force_ack    = 1'b0;
    bus.m_cs_i   = '0;
    bus.m_we_i   = '0;
    bus.m_addr_i = '0;
    bus.m_sel_i  = '0;
    bus.m_data_i = '0;
    step();
    step();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_ack", 32'(bus.m_ack_o), 32'h0);
    chk("rst_mdata", bus.m_data_o, 32'h0);
    chk("rst_scs", 32'(bus.s_cs_o), 32'h0);
    rst = 1'b0;
    ref_reset();

    // single read by m1 from addr 0 (switch value A5)
    set_m(1, 1'b0, '0, 4'hF, 32'h0);
    bus.m_cs_i[1] = 1'b1;
    step();
    chk("rd_c1_scs", 32'(bus.s_cs_o), 32'h1);
    chk("rd_c1_grant", 32'(grant_o), 32'h2);
    chk("rd_c1_noack", 32'(bus.m_ack_o), 32'h0);
    step();
    chk("rd_c2_ack", 32'(bus.m_ack_o), 32'h2);
    chk("rd_c2_data", bus.m_data_o, 32'h000000A5);
    bus.m_cs_i[1] = 1'b0;
    step();
    chk("rd_c3_grant", 32'(grant_o), 32'h0);
    chk("rd_c3_ack", 32'(bus.m_ack_o), 32'h0);

    // contention m0 + m2 from reset
    do_reset();
    set_m(0, 1'b0, 6'd2, 4'hF, 32'h0);
    set_m(2, 1'b0, 6'd3, 4'hF, 32'h0);
    bus.m_cs_i = 4'b0101;
    step();
    chk("ct_grant0", 32'(grant_o), 32'h1);
    chk("ct_addr0", 32'(bus.s_addr_o), 32'h2);
    step();
    chk("ct_ack0", 32'(bus.m_ack_o), 32'h1);
    chk("ct_data0", bus.m_data_o, ref_mem[2]);
    bus.m_cs_i[0] = 1'b0;
    step();
    chk("ct_gap_grant", 32'(grant_o), 32'h0);
    chk("ct_gap_scs", 32'(bus.s_cs_o), 32'h0);
    step();
    chk("ct_grant2", 32'(grant_o), 32'h4);
    chk("ct_addr2", 32'(bus.s_addr_o), 32'h3);
    step();
    chk("ct_ack2", 32'(bus.m_ack_o), 32'h4);
    chk("ct_data2", bus.m_data_o, ref_mem[3]);
    bus.m_cs_i[2] = 1'b0;
    step();
    chk("ct_end", 32'(grant_o), 32'h0);

    // fairness: all four hold requests for 12 transfers
    do_reset();
    for (int k = 0; k < NM; k++) set_m(k, 1'b0, AW'(k), 4'hF, 32'h0);
    bus.m_cs_i = '1;
    n = 0;
    cyc = 0;
    pulse_ok = 1'b1;
    while (n < 12 && cyc < 100) begin
      step();
      cyc++;
      if (bus.m_ack_o != '0) begin
        chk($sformatf("fair_%0d", n), 32'(bus.m_ack_o), 32'(1 << (n % NM)));
        n++;
        step();
        cyc++;
        if (bus.m_ack_o != '0) pulse_ok = 1'b0;
      end
    end
    chk("fair_count", n, 12);
    chk("fair_pulse", 32'(pulse_ok), 32'h1);
    bus.m_cs_i = '0;
    step();

    // byte write by m3, readback by m0
    do_reset();
    set_m(3, 1'b1, 6'd1, 4'b0001, 32'h12345678);
    bus.m_cs_i[3] = 1'b1;
    step();
    chk("bw_sel", 32'(bus.s_sel_o), 32'h1);
    chk("bw_we", 32'(bus.s_we_o), 32'h1);
    chk("bw_addr", 32'(bus.s_addr_o), 32'h1);
    chk("bw_data", bus.s_data_o, 32'h12345678);
    step();
    chk("bw_ack", 32'(bus.m_ack_o), 32'h8);
    ref_mem[1] = merge(ref_mem[1], 4'b0001, 32'h12345678);
    bus.m_cs_i[3] = 1'b0;
    bus.m_we_i[3] = 1'b0;
    mptr = 0;
    step();
    xfer(0, 1'b0, 6'd1, 4'hF, 32'h0, rd);
    chk("rb_byte", 32'(rd[7:0]), 32'h78);
    chk("rb_word", rd, ref_mem[1]);

    // abort by m2, then a late ack must not reach anyone
    do_reset();
    set_m(2, 1'b0, 6'd4, 4'hF, 32'h0);
    bus.m_cs_i[2] = 1'b1;
    step();
    chk("ab_grant", 32'(grant_o), 32'h4);
    bus.m_cs_i[2] = 1'b0;
    #1;
    chk("ab_scs", 32'(bus.s_cs_o), 32'h0);
    step();
    force_ack = 1'b1;
    #1;
    chk("ab_idle", 32'(grant_o), 32'h0);
    chk("ab_late_ack", 32'(bus.m_ack_o), 32'h0);
    chk("ab_busy", 32'(busy_o), 32'h0);
    step();
    force_ack = 1'b0;

    // reset while BUSY (m1 granted moves the pointer to 2)
    do_reset();
    set_m(1, 1'b0, 6'd5, 4'hF, 32'h0);
    bus.m_cs_i[1] = 1'b1;
    step();
    chk("rs_busy_before", 32'(busy_o), 32'h1);
    rst = 1'b1;
    bus.m_cs_i = '0;
    step();
    chk("rs_grant", 32'(grant_o), 32'h0);
    chk("rs_scs", 32'(bus.s_cs_o), 32'h0);
    chk("rs_ack", 32'(bus.m_ack_o), 32'h0);
    chk("rs_busy", 32'(busy_o), 32'h0);
    rst = 1'b0;
    ref_reset();
    set_m(0, 1'b0, 6'd6, 4'hF, 32'h0);
    set_m(3, 1'b0, 6'd7, 4'hF, 32'h0);
    bus.m_cs_i = 4'b1001;
    step();
    chk("rs_ptr", 32'(grant_o), 32'h1);
    step();
    bus.m_cs_i = '0;
    step();
    step();

    // slave never acks
    do_reset();
    ack_en = 1'b0;
    set_m(1, 1'b0, 6'd9, 4'hF, 32'h0);
    bus.m_cs_i[1] = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("to_wait_ack_%0d", c), 32'(bus.m_ack_o), 32'h0);
      chk($sformatf("to_wait_pulse_%0d", c), 32'(timeout_o), 32'h0);
    end
    step();
    chk("to_ack", 32'(bus.m_ack_o), 32'h2);
    chk("to_pulse", 32'(timeout_o), 32'h1);
    chk("to_data", bus.m_data_o, 32'h0);
    bus.m_cs_i[1] = 1'b0;
    step();
    chk("to_idle", 32'(grant_o), 32'h0);
    chk("to_pulse_end", 32'(timeout_o), 32'h0);
`else
    busy_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (!busy_o || bus.m_ack_o != '0) busy_ok = 1'b0;
    end
    chk("nto_busy_100", 32'(busy_ok), 32'h1);
    bus.m_cs_i[1] = 1'b0;
    step();
    chk("nto_abort_idle", 32'(grant_o), 32'h0);
`endif
    ack_en = 1'b1;

    // randomized request sets against the rotation model
    do_reset();
    for (int b = 0; b < 30; b++) run_batch(NM'($urandom_range(1, (1 << NM) - 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin arbiter that shares one wishbone slave port (e.g. the board I/O register block) between N wishbone masters (CPU data port, debug monitor, DMA).
- Grants one master at a time and forwards its cycle to the slave.
- Returns the slave ack and data to the granted master only.
- Releases the bus the cycle after ack, so a slave that re-samples chip-select on every free cycle never sees a stale request.

Parameters:
- MASTER_NUM, 4, number of masters (2..8).
- DEV_ADDR_BITS, 8, slave address-space width; word address is [DEV_ADDR_BITS-1:2].
- TIMEOUT_CYCLES, 255, cycles from grant to forced completion (used only with the optional feature).

Ports:
- clk  in  1  main clock; the masters and the slave run on it.
- rst  in  1  synchronous reset, active-high.
- m_cs_i  in  MASTER_NUM  per-master cycle request.
- m_addr_i  in  MASTER_NUM*(DEV_ADDR_BITS-2)  packed word addresses; master k at slice k.
- m_sel_i  in  MASTER_NUM*4  packed byte selects.
- m_data_i  in  MASTER_NUM*32  packed write data.
- m_we_i  in  MASTER_NUM  write enables.
- m_data_o  out  32  read data, shared by all masters; valid only with that master's ack.
- m_ack_o  out  MASTER_NUM  per-master ack.
- s_cs_o  out  1  slave chip-select.
- s_addr_o  out  DEV_ADDR_BITS-2  slave address.
- s_sel_o  out  4  slave byte select.
- s_data_o  out  32  slave write data.
- s_we_o  out  1  slave write enable.
- s_data_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  MASTER_NUM  one-hot current grant; all zero when idle.
- busy_o  out  1  high in BUSY.

Behaviour:
- Reset: state=IDLE, grant_o=0, priority pointer=0 (master 0 highest), busy_o=0, all m_ack_o=0, m_data_o=0, s_cs_o=0.
- IDLE:
  - If any m_cs_i is high, pick the first requester scanning from the pointer upward with wrap (k=ptr, ptr+1, …, MASTER_NUM-1, 0, …).
  - Register grant_o=onehot(k); move to BUSY; pointer <= (k+1) mod MASTER_NUM.
  - No request: stay in IDLE; pointer unchanged.
- BUSY, combinational muxing:
  - s_cs_o = m_cs_i[k].
  - s_addr_o, s_sel_o, s_data_o and s_we_o = slice k of the master inputs.
  - m_ack_o[k] = s_ack_i; m_data_o = s_data_i; all other m_ack_o bits = 0.
- BUSY transitions:
  - s_ack_i=1: go to IDLE next edge and clear grant_o.
  - m_cs_i[k]=0 (master abort): go to IDLE next edge and clear grant_o.
  - Otherwise stay in BUSY.
- IDLE outputs: s_cs_o=0 and all slave-side outputs=0; s_ack_i is ignored and m_ack_o stays 0 (this covers a late ack after an abort).
- Latency: request in cycle 0 → s_cs_o high in cycle 1 → slave acks in cycle 2 (one-cycle registered slave) → IDLE in cycle 3, when a new grant may be made. Minimum 3 cycles per transfer.
- Simultaneous requests: resolved only in IDLE; the grant is never preempted. A request arriving during BUSY waits.
- Fairness: under continuous requests from all masters, grants rotate 0,1,2,3,0,…
- Reset mid-operation: returns to the reset values next edge; an in-flight cycle is dropped without ack.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on grant and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without s_ack_i, the arbiter drives m_ack_o[k]=1 with m_data_o=0 for one cycle and goes to IDLE.
  - Adds port timeout_o (out, 1): a one-cycle pulse at the forced ack, reset value 0.
- Undefined: no counter and no timeout_o port; BUSY waits indefinitely for s_ack_i or abort.

Decomposition:
- Shared include (define.vh, already used by the device blocks) holds:
  - state encodings ARB_IDLE=1'b0 and ARB_BUSY=1'b1;
  - constant WB_DATA_BITS=32 and WB_SEL_BITS=4.
- One sub-module, wb_rr_pick: purely combinational. Inputs request vector and pointer; outputs one-hot winner and binary index. Parameterised by MASTER_NUM.
- Packing/unpacking of master slices and the FSM stay in wb_arbiter.

Test Plan:
- Single read: m1 reads addr 0 of a board slave with switch=8'hA5 → s_cs_o high cycle 1, m_ack_o=4'b0010 cycle 2 with m_data_o=32'h000000A5, grant_o=0 cycle 3.
- Contention: m0 and m2 request together at reset → m0 served first; pointer=1; m2 granted on the first IDLE cycle after m0's ack. No overlap of s_cs_o between the two.
- Fairness: all four hold m_cs_i high for 12 transfers → grant order 0,1,2,3 repeated three times. Each m_ack_o is a single-cycle pulse.
- Byte write: m3 writes addr 1, sel=4'b0001, data=32'h12345678 → slave sees s_sel_o=4'b0001 and s_we_o=1; a readback via m0 returns low byte 8'h78.
- Abort and reset: m2 drops cs in cycle 1 before ack → IDLE next cycle and the late slave ack does not reach any master. Separately, rst asserted while BUSY → next edge grant_o=0, s_cs_o=0, pointer=0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks) → m_ack_o[k] and timeout_o pulse after 4 BUSY cycles with m_data_o=0. Without the macro, the bench confirms BUSY persists for 100 cycles.
